// File: rtl/alu_result_fifo_if.sv
// Bundles the ALU-side push port and the writeback-side pop port of the
// ALU result FIFO, plus its occupancy and sticky drop indication.
interface alu_result_fifo_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OPW   = 2,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAGW  = 8
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [OPW-1:0]   in_opcode;
   logic [WIDTH-1:0] alu_out;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [OPW-1:0]   out_opcode;
   logic             out_zero;
   logic [TAGW-1:0]  out_tag;
   logic [CW-1:0]    count;
   logic             drop_err;

   // Environment side: ALU producer and writeback consumer
   modport mst (
      output in_valid, in_opcode, alu_out, out_ready,
      input  in_ready, out_valid, out_data, out_opcode, out_zero, out_tag,
             count, drop_err
   );

   // FIFO side
   modport slv (
      input  in_valid, in_opcode, alu_out, out_ready,
      output in_ready, out_valid, out_data, out_opcode, out_zero, out_tag,
             count, drop_err
   );
endinterface

// File: rtl/alu_result_fifo.sv
// ALU result FIFO: captures {result, opcode, zero flag, sequence tag} per
// accepted ALU result and presents the oldest entry to a stalling writeback
// consumer. No fall-through; a push is visible at the head one cycle later.
module alu_result_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OPW   = 2,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAGW  = 8
) (
   input logic            clk,
   input logic            rst,
   alu_result_fifo_if.slv bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [OPW-1:0]   op;
      logic             zero;
      logic [TAGW-1:0]  tag;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          head_q, head_d;
   entry_t          wr_entry;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [TAGW-1:0] tag_q, tag_d;
   logic            valid_q, ready_q, drop_q, drop_d;
   logic            push, pop;

   // Next-state: pointers, occupancy, tag, sticky drop and the next head entry
   always_comb begin
      push     = bus.in_valid & ready_q;
      pop      = valid_q & bus.out_ready;
      wr_entry = '{data: bus.alu_out,
                   op:   bus.in_opcode,
                   zero: (bus.alu_out == '0),
                   tag:  tag_q};
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      tag_d    = tag_q;
      drop_d   = drop_q | (bus.in_valid & ~ready_q);

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         tag_d    = tag_q + TAGW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end

      // Pointers only coincide on a legal push when the new head is the
      // entry being written this cycle (empty, or one entry being popped).
      if (push && (wr_ptr_q == rd_ptr_d)) begin
         head_d = wr_entry;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // State and registered outputs; reset discards all contents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         head_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         tag_q    <= '0;
         valid_q  <= 1'b0;
         ready_q  <= 1'b1;
         drop_q   <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
         end
         head_q   <= head_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         tag_q    <= tag_d;
         valid_q  <= (count_d != '0);
         ready_q  <= (count_d != CW'(DEPTH));
         drop_q   <= drop_d;
      end
   end

   assign bus.in_ready   = ready_q;
   assign bus.out_valid  = valid_q;
   assign bus.out_data   = head_q.data;
   assign bus.out_opcode = head_q.op;
   assign bus.out_zero   = head_q.zero;
   assign bus.out_tag    = head_q.tag;
   assign bus.count      = count_q;
   assign bus.drop_err   = drop_q;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo with a scoreboard queue. A second
// instance with TAGW=2 sees identical stimulus to exercise tag wrap.
module tb_alu_result_fifo;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned OPW   = 2;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TAGW  = 8;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [OPW-1:0]   op;
      logic             zero;
      logic [TAGW-1:0]  tag;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] alu_out = '0;
   logic [OPW-1:0]   in_opcode = '0;
   logic             out_ready = 1'b0;

   int               checks = 0;
   int               errors = 0;
   exp_t             sb[$];
   logic [TAGW-1:0]  exp_tag = '0;
   logic             exp_drop = 1'b0;

   alu_result_fifo_if #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH), .TAGW(TAGW)) bus ();
   alu_result_fifo_if #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH), .TAGW(2))    bus2 ();

   assign bus.in_valid   = in_valid;
   assign bus.alu_out    = alu_out;
   assign bus.in_opcode  = in_opcode;
   assign bus.out_ready  = out_ready;
   assign bus2.in_valid  = in_valid;
   assign bus2.alu_out   = alu_out;
   assign bus2.in_opcode = in_opcode;
   assign bus2.out_ready = out_ready;

   alu_result_fifo #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   alu_result_fifo #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH), .TAGW(2)) dut_t2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   // Compare all status outputs and the head entry against the model
   task automatic check_state();
      chk("count", 64'(bus.count), 64'(sb.size()));
      chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
      chk("in_ready", 64'(bus.in_ready), 64'(sb.size() < int'(DEPTH)));
      chk("drop_err", 64'(bus.drop_err), 64'(exp_drop));
      chk("count_t2", 64'(bus2.count), 64'(sb.size()));
      if (sb.size() != 0) begin
         chk("out_data", 64'(bus.out_data), 64'(sb[0].data));
         chk("out_opcode", 64'(bus.out_opcode), 64'(sb[0].op));
         chk("out_zero", 64'(bus.out_zero), 64'(sb[0].zero));
         chk("out_tag", 64'(bus.out_tag), 64'(sb[0].tag));
         chk("out_tag_t2", 64'(bus2.out_tag), 64'(sb[0].tag[1:0]));
      end
   endtask

   // One clock cycle of stimulus, entered and left at the falling edge
   task automatic cycle(input logic v, input logic [WIDTH-1:0] d,
                        input logic [OPW-1:0] op, input logic rdy);
      logic acc;
      exp_t e;
      in_valid  = v;
      alu_out   = d;
      in_opcode = op;
      out_ready = rdy;
      acc = v && (sb.size() < int'(DEPTH));
      if (v && !acc) exp_drop = 1'b1;
      #1;
      chk("in_ready_pre", 64'(bus.in_ready), 64'(sb.size() < int'(DEPTH)));
      if (rdy && sb.size() != 0) void'(sb.pop_front());
      if (acc) begin
         e.data = d;
         e.op   = op;
         e.zero = (d == '0);
         e.tag  = exp_tag;
         sb.push_back(e);
         exp_tag = exp_tag + 8'd1;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check_state();
   endtask

   // Assert reset mid-cycle and check the asynchronous clear before any edge
   task automatic mid_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_drop_err", 64'(bus.drop_err), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
      sb.delete();
      exp_tag  = '0;
      exp_drop = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Power-on reset
      @(negedge clk);
      @(negedge clk);
      chk("por_out_valid", 64'(bus.out_valid), 64'd0);
      chk("por_in_ready", 64'(bus.in_ready), 64'd1);
      chk("por_out_opcode", 64'(bus.out_opcode), 64'd0);
      chk("por_out_zero", 64'(bus.out_zero), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_state();

      // Single op, then a stalled idle cycle (head must hold)
      cycle(1'b1, 32'h0000_0005, 2'd2, 1'b0);
      chk("single_data", 64'(bus.out_data), 64'h5);
      chk("single_tag", 64'(bus.out_tag), 64'h0);
      cycle(1'b0, 32'h0, 2'd0, 1'b0);
      cycle(1'b1, 32'h0000_0007, 2'd1, 1'b0);

      // Reset mid-operation discards the contents
      mid_reset();
      @(negedge clk);
      check_state();

      // Fill then drop: fifth value must never reach the head
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 32'h0000_0011 + 32'(i), 2'(i), 1'b0);
      end
      chk("full_count", 64'(bus.count), 64'd4);
      chk("full_drop", 64'(bus.drop_err), 64'd1);
      // Full with out_ready=1: pop happens but the push is still refused
      cycle(1'b1, 32'hDEAD_BEEF, 2'd3, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 32'h0, 2'd0, 1'b1);
      end
      chk("drained_count", 64'(bus.count), 64'd0);
      // Empty: out_ready ignored
      cycle(1'b0, 32'h0, 2'd0, 1'b1);

      // Simultaneous push/pop at count=2
      cycle(1'b1, 32'h0000_0A00, 2'd0, 1'b0);
      cycle(1'b1, 32'h0000_0A01, 2'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 32'h0000_0B00 + 32'(i), 2'(i + 2), 1'b1);
         chk("simul_count", 64'(bus.count), 64'd2);
      end
      cycle(1'b0, 32'h0, 2'd0, 1'b1);
      cycle(1'b0, 32'h0, 2'd0, 1'b1);

      // Wrap: push into empty then 10 push/pop pairs, zeros mixed in
      cycle(1'b1, 32'h0, 2'd3, 1'b0);
      chk("zero_flag", 64'(bus.out_zero), 64'd1);
      for (int i = 0; i < 10; i++) begin
         logic [WIDTH-1:0] d;
         d = (i % 3 == 0) ? 32'h0 : $urandom;
         cycle(1'b1, d, 2'($urandom_range(3, 0)), 1'b1);
      end
      cycle(1'b0, 32'h0, 2'd0, 1'b1);
      cycle(1'b0, 32'h0, 2'd0, 1'b1);

      // Random mix including stalls and overflow attempts
      for (int i = 0; i < 40; i++) begin
         cycle(1'($urandom_range(1, 0)), $urandom, 2'($urandom_range(3, 0)),
               1'($urandom_range(3, 0) == 0));
      end

      // Final reset clears the sticky drop flag
      mid_reset();
      @(negedge clk);
      check_state();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
